// File: rtl/s27_key_pkg.sv
// Shared types and constants for the s27 key-load controller.
// S27_KEY_PARITY_EN adds a trailing even-parity bit to every key fetch.
package s27_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMMIT,
        LOADED,
        ERROR
    } key_state_e;

    localparam int KEY_W_DEF  = 9;
    localparam int TO_CYC_DEF = 15;

    // Number of serial transfers that make up one complete key fetch.
    function automatic int xfer_limit(input int key_w);
`ifdef S27_KEY_PARITY_EN
        return key_w + 1;
`else
        return key_w;
`endif
    endfunction

endpackage

// File: rtl/s27_key_timer.sv
// Stall timer for the key-memory handshake.
// It counts idle request cycles and saturates at TO_CYC, where expired is raised.
module s27_key_timer #(
    parameter int TO_CYC = 15,
    parameter int TO_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TO_CYC);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (en && count != LIMIT)
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/s27_key_ctrl.sv
// Key-load controller for the logic-locked s27 core: serial fetch, atomic commit, core gating.
// Build with S27_KEY_PARITY_EN to fetch and check an extra even-parity bit.
module s27_key_ctrl
    import s27_key_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int TO_CYC = TO_CYC_DEF,
    parameter int CNT_W  = 4,
    parameter int TO_W   = 4
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    output logic             KM_REQ,
    input  logic             KM_ACK,
    input  logic             KM_BIT,
    output logic [KEY_W-1:0] KEY,
    output logic             CORE_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(xfer_limit(KEY_W) - 1);

    key_state_e       state;
    logic [CNT_W-1:0] idx;
    logic [KEY_W-1:0] shreg;
    logic             transfer;
    logic             tmr_clear;
    logic             tmr_en;
    logic             expired;
    logic             parity_bad;

    assign transfer  = KM_REQ & KM_ACK;
    assign tmr_en    = (state == FETCH) & ~transfer;
    assign tmr_clear = (state != FETCH) | transfer | START;

`ifdef S27_KEY_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(KEY_W);
    logic par_bit;

    always_ff @(posedge CK) begin
        if (RST || START)
            par_bit <= 1'b0;
        else if (state == FETCH && transfer && idx == PAR_IDX)
            par_bit <= KM_BIT;
    end

    assign parity_bad = ^{shreg, par_bit};
`else
    assign parity_bad = 1'b0;
`endif

    s27_key_timer #(
        .TO_CYC (TO_CYC),
        .TO_W   (TO_W)
    ) u_timer (
        .clk     (CK),
        .rst     (RST),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (expired)
    );

    // START restarts from any state, so it is handled ahead of the per-state work.
    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= IDLE;
            idx     <= '0;
            shreg   <= '0;
            KEY     <= '0;
            KM_REQ  <= 1'b0;
            CORE_EN <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (START) begin
                state   <= FETCH;
                idx     <= '0;
                shreg   <= '0;
                KEY     <= '0;
                KM_REQ  <= 1'b1;
                CORE_EN <= 1'b0;
                BUSY    <= 1'b1;
                ERR     <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (transfer) begin
                            for (int i = 0; i < KEY_W; i++)
                                if (idx == CNT_W'(i))
                                    shreg[i] <= KM_BIT;
                            idx <= idx + 1'b1;
                            if (idx == LAST_IDX) begin
                                state  <= COMMIT;
                                KM_REQ <= 1'b0;
                            end
                        end else if (expired) begin
                            state  <= ERROR;
                            ERR    <= 1'b1;
                            KEY    <= '0;
                            KM_REQ <= 1'b0;
                            BUSY   <= 1'b0;
                        end
                    end
                    COMMIT: begin
                        BUSY <= 1'b0;
                        if (parity_bad) begin
                            state <= ERROR;
                            ERR   <= 1'b1;
                            KEY   <= '0;
                        end else begin
                            state   <= LOADED;
                            KEY     <= shreg;
                            DONE    <= 1'b1;
                            CORE_EN <= 1'b1;
                        end
                    end
                    IDLE, LOADED: begin
                    end
                    ERROR: begin
                        KEY     <= '0;
                        CORE_EN <= 1'b0;
                        KM_REQ  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_s27_key_ctrl.sv
// Self-checking bench for s27_key_ctrl; committed keys are scored against a queue of expected keys.
// Build with S27_KEY_PARITY_EN to also exercise the parity-bit path.
module tb_s27_key_ctrl;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       KM_REQ;
    logic       KM_ACK = 1'b0;
    logic       KM_BIT = 1'b0;
    logic [8:0] KEY;
    logic       CORE_EN;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int         numChecks = 0;
    int         numFails  = 0;
    int         doneCount = 0;
    logic [8:0] expQ[$];

    s27_key_ctrl dut (
        .CK      (CK),
        .RST     (RST),
        .START   (START),
        .KM_REQ  (KM_REQ),
        .KM_ACK  (KM_ACK),
        .KM_BIT  (KM_BIT),
        .KEY     (KEY),
        .CORE_EN (CORE_EN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CK = ~CK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Every DONE pulse must match the oldest outstanding key.
    always @(negedge CK) begin
        if (DONE === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0)
                checkOutput("done_unexpected", 32'(DONE), 32'd0);
            else
                checkOutput("sb_key", 32'(KEY), 32'(expQ.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic startLoad();
        START = 1'b1;
        tick();
        START = 1'b0;
        checkOutput("req_latency", 32'(KM_REQ), 32'd1);
        checkOutput("core_en_drop", 32'(CORE_EN), 32'd0);
        checkOutput("key_cleared", 32'(KEY), 32'd0);
        checkOutput("busy_fetch", 32'(BUSY), 32'd1);
    endtask

    task automatic sendBit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            KM_ACK = 1'b0;
            tick();
            checkOutput("req_held", 32'(KM_REQ), 32'd1);
            checkOutput("no_err_gap", 32'(ERR), 32'd0);
        end
        KM_ACK = 1'b1;
        KM_BIT = b;
        tick();
        KM_ACK = 1'b0;
        checkOutput("key_hidden", 32'(KEY), 32'd0);
    endtask

    task automatic applyStimulus(input logic [8:0] key, input int maxGap);
        int doneBefore;
        doneBefore = doneCount;
        expQ.push_back(key);
        startLoad();
        for (int i = 0; i < 9; i++)
            sendBit(key[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
`ifdef S27_KEY_PARITY_EN
        sendBit(^key, 0);
`endif
        checkOutput("core_en_commit", 32'(CORE_EN), 32'd0);
        tick();
        checkOutput("core_en_loaded", 32'(CORE_EN), 32'd1);
        checkOutput("key_loaded", 32'(KEY), 32'(key));
        checkOutput("busy_loaded", 32'(BUSY), 32'd0);
        checkOutput("err_loaded", 32'(ERR), 32'd0);
        tick();
        checkOutput("done_one_cycle", 32'(DONE), 32'd0);
        checkOutput("done_pulses", 32'(doneCount - doneBefore), 32'd1);
    endtask

    initial begin
        logic [8:0] keyA;
        int doneSnap;
        keyA = 9'b111011010;

        tick();
        tick();
        RST = 1'b0;
        checkOutput("rst_key", 32'(KEY), 32'd0);
        checkOutput("rst_core_en", 32'(CORE_EN), 32'd0);
        checkOutput("rst_req", 32'(KM_REQ), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_done", 32'(DONE), 32'd0);
        checkOutput("rst_err", 32'(ERR), 32'd0);

        $display("[TB] back-to-back load");
        applyStimulus(keyA, 0);

        $display("[TB] load with ACK gaps");
        applyStimulus(keyA, 3);
        applyStimulus(keyA, 3);

        // ACK with no request outstanding must not disturb a loaded key.
        doneSnap = doneCount;
        for (int i = 0; i < 4; i++) begin
            KM_ACK = 1'b1;
            KM_BIT = ~KM_BIT;
            tick();
            checkOutput("idle_ack_req", 32'(KM_REQ), 32'd0);
        end
        KM_ACK = 1'b0;
        checkOutput("idle_ack_key", 32'(KEY), 32'(keyA));
        checkOutput("idle_ack_done", 32'(doneCount - doneSnap), 32'd0);

        $display("[TB] stalled key memory");
        startLoad();
        for (int i = 0; i < 4; i++)
            sendBit(keyA[i], 0);
        repeat (14) tick();
        checkOutput("timeout_early", 32'(ERR), 32'd0);
        checkOutput("timeout_req_hi", 32'(KM_REQ), 32'd1);
        repeat (2) tick();
        checkOutput("timeout_err", 32'(ERR), 32'd1);
        checkOutput("timeout_key", 32'(KEY), 32'd0);
        checkOutput("timeout_core_en", 32'(CORE_EN), 32'd0);
        checkOutput("timeout_req_lo", 32'(KM_REQ), 32'd0);
        repeat (3) tick();
        checkOutput("err_sticky", 32'(ERR), 32'd1);
        applyStimulus(keyA, 0);

        $display("[TB] reset mid-load");
        startLoad();
        for (int i = 0; i < 5; i++)
            sendBit(keyA[i], 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("midrst_key", 32'(KEY), 32'd0);
        checkOutput("midrst_busy", 32'(BUSY), 32'd0);
        checkOutput("midrst_req", 32'(KM_REQ), 32'd0);
        checkOutput("midrst_core_en", 32'(CORE_EN), 32'd0);
        tick();
        checkOutput("midrst_idle_req", 32'(KM_REQ), 32'd0);
        applyStimulus(keyA, 0);

        $display("[TB] reload from LOADED with all ones");
        applyStimulus(9'h1FF, 2);

        $display("[TB] restart in FETCH");
        startLoad();
        for (int i = 0; i < 3; i++)
            sendBit(1'b1, 0);
        applyStimulus(9'h0A5, 1);

`ifdef S27_KEY_PARITY_EN
        $display("[TB] bad parity bit");
        doneSnap = doneCount;
        startLoad();
        for (int i = 0; i < 9; i++)
            sendBit(keyA[i], 0);
        sendBit(~(^keyA), 0);
        tick();
        tick();
        checkOutput("par_err", 32'(ERR), 32'd1);
        checkOutput("par_key", 32'(KEY), 32'd0);
        checkOutput("par_core_en", 32'(CORE_EN), 32'd0);
        checkOutput("par_no_done", 32'(doneCount - doneSnap), 32'd0);
        applyStimulus(keyA, 0);
`endif

        repeat (3) tick();
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
